garage_door_input_conditioner: RTL and testbench
================================================

Name: garage_door_input_conditioner

Overview:
- Front-end stage directly upstream of the garage door FSM; conditions the raw wall-button and the two raw limit-switch inputs.
- Each input is synchronised with a 2-flop synchroniser and debounced.
- Produces a one-cycle `Activate` pulse per debounced button press, plus debounced `UP_Max` / `DN_Max` levels that connect straight to the FSM's ports of the same names.

Parameters:
- `DB_CYCLES`, 4: consecutive synchronised cycles an input must hold a new value before the debounced output changes; legal range 1..255.

Ports:
- `CLK`  input  1  system clock; all logic on the rising edge.
- `RST`  input  1  asynchronous, active-low reset.
- `BTN_raw`  input  1  raw wall-button level, asynchronous, 1 = pressed.
- `UP_Max_raw`  input  1  raw upper limit switch, asynchronous.
- `DN_Max_raw`  input  1  raw lower limit switch, asynchronous.
- `Activate`  output  1  registered one-cycle pulse per debounced press.
- `UP_Max`  output  1  registered debounced upper limit.
- `DN_Max`  output  1  registered debounced lower limit.
- `FAULT`  output  1  registered limit-conflict flag; see Optional Feature.

Behaviour:

Reset:
- `RST` = 0 asynchronously clears all synchroniser flops, debounce counters, and stable registers.
- FSM goes to IDLE.
- `Activate`, `UP_Max`, `DN_Max`, `FAULT` are all 0.

Per-channel debounce (three identical instances):
- 2-flop synchroniser: `s1` <= raw, `s2` <= `s1`.
- Counter width is the minimum needed to hold `DB_CYCLES`.
- Each edge:
  - if `s2` == stable: counter <= 0.
  - else if counter == `DB_CYCLES`-1: stable <= `s2`, counter <= 0.
  - else counter <= counter+1.
- Latency: a raw change first sampled at edge 0 changes the stable output at edge `DB_CYCLES`+2, i.e. 6 edges with default parameters.
- Any run of `s2` mismatch shorter than `DB_CYCLES` cycles causes no output change; the counter restarts from 0 after each break in the run.
- With `DB_CYCLES` = 1, the stable value follows `s2` with one cycle of delay.

Button FSM (Moore, input is `btn_stable`):
- IDLE: `Activate` = 0; `btn_stable` = 1 -> PULSE.
- PULSE: `Activate` = 1; `btn_stable` = 1 -> HELD, else -> IDLE.
- HELD: `Activate` = 0; `btn_stable` = 0 -> IDLE.
- Exactly one `Activate` cycle per debounced press, one edge after `btn_stable` rises: edge `DB_CYCLES`+3 from the raw press.
- A held button never re-triggers. Release plus re-press requires a full debounce in each direction.

Boundary cases:
- Reset mid-press: the button is treated as released at reset. If it is still held after `RST` deasserts, one `Activate` is produced after the full latency.
- Simultaneous edges on all three raw inputs are processed independently with identical latency.
- A bounce during the release debounce does not produce a second pulse.

Optional Feature:
- Macro: `GARAGE_LIMIT_FAULT_EN`.
- Defined:
  - `FAULT` <= (debounced `UP_Max` & debounced `DN_Max`), registered, so it is high one edge after both stable values are 1.
  - While `FAULT` = 1, the FSM holds in IDLE/HELD and no `Activate` is issued. A press already in PULSE completes.
  - A press whose `btn_stable` rise coincides with `FAULT` = 1 is discarded. The FSM goes to HELD and waits for release.
- Undefined:
  - `FAULT` is tied to 0.
  - The FSM ignores limit states entirely.

Test Plan (`DB_CYCLES` = 4, 10 ns clock, `RST` released at 20 ns):
1. Reset: `RST` = 0 with all raw inputs = 1 -> all outputs 0 immediately (asynchronous), before any clock edge.
2. Clean press: `BTN_raw` 0->1 held 200 ns, sampled at edge N -> `Activate` = 1 for exactly the cycle after edge N+7, then 0 for the rest of the hold; release and re-press -> one more pulse.
3. Bounce: `BTN_raw` toggles every 20 ns for 100 ns, then settles at 1 -> exactly one `Activate` pulse, 7 edges after the final settling sample; a 30 ns glitch alone -> no pulse.
4. Limits: `DN_Max_raw` = 1 at edge M -> `DN_Max` rises at edge M+6; a 20 ns `UP_Max_raw` glitch -> `UP_Max` stays 0.
5. Reset mid-press: assert `RST` = 0 during a held press, release it with the button still held -> `Activate` pulses once, 7 edges after the first post-reset sample.
6. `GARAGE_LIMIT_FAULT_EN` build: both raw limits = 1 -> `FAULT` = 1 at edge +7; a press during `FAULT` -> no `Activate`. Without the macro -> `FAULT` stays 0 and the press pulses normally.

Source files
------------

// File: rtl/garage_door_input_conditioner.sv
// Purpose : synchronise and debounce the wall button and both limit switches; one Activate pulse per press.
// Latency : raw edge sampled at edge 0 -> UP_Max/DN_Max at edge DB_CYCLES+2, Activate at edge DB_CYCLES+3.
// Backpressure: none; free-running level inputs, outputs are plain registered levels/pulses.
//
// Ports: CLK clock, RST async active-low reset, BTN_raw/UP_Max_raw/DN_Max_raw raw asynchronous
//        inputs, Activate one-cycle press pulse, UP_Max/DN_Max debounced limits, FAULT limit conflict.
// Optional feature macro: GARAGE_LIMIT_FAULT_EN (both limits active -> FAULT, new presses suppressed).
module garage_door_input_conditioner #(
  parameter int DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_raw,
  input  logic UP_Max_raw,
  input  logic DN_Max_raw,
  output logic Activate,
  output logic UP_Max,
  output logic DN_Max,
  output logic FAULT
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Channel index: 0 = button, 1 = upper limit, 2 = lower limit.
  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    deb;   // debounce decision register (compared against s2)
  logic [2:0]    lvl;   // registered debounced levels driven to the outputs/FSM
  logic [CW-1:0] cnt [3];

  assign raw = {DN_Max_raw, UP_Max_raw, BTN_raw};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
      lvl <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      lvl <= deb;
      for (int i = 0; i < 3; i++) begin
        // Any sample agreeing with the current value breaks the run and restarts the count.
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign UP_Max = lvl[1];
  assign DN_Max = lvl[2];

  logic fault_q;

`ifdef GARAGE_LIMIT_FAULT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) fault_q <= 1'b0;
    else      fault_q <= lvl[1] & lvl[2];
  end
`else
  assign fault_q = 1'b0;
`endif

  assign FAULT = fault_q;

  typedef enum logic [1:0] {IDLE, PULSE, HELD} btn_state_t;

  btn_state_t state;
  logic       act_q;

  // Activate is registered alongside the state so it is high exactly while in PULSE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      act_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lvl[0]) begin
            // A press that arrives while the limits conflict is swallowed; wait for release.
            if (fault_q) begin
              state <= HELD;
              act_q <= 1'b0;
            end else begin
              state <= PULSE;
              act_q <= 1'b1;
            end
          end else begin
            act_q <= 1'b0;
          end
        end
        PULSE: begin
          act_q <= 1'b0;
          state <= lvl[0] ? HELD : IDLE;
        end
        HELD: begin
          act_q <= 1'b0;
          if (!lvl[0]) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          act_q <= 1'b0;
        end
      endcase
    end
  end

  assign Activate = act_q;

endmodule

// File: tb/tb_garage_door_input_conditioner.sv
module tb_garage_door_input_conditioner;

  localparam int DB = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BTN_raw = 1'b1;
  logic UP_Max_raw = 1'b1;
  logic DN_Max_raw = 1'b1;
  logic Activate, UP_Max, DN_Max, FAULT;

  int checks = 0;
  int errors = 0;

  garage_door_input_conditioner #(.DB_CYCLES(DB)) dut (
    .CLK(CLK), .RST(RST), .BTN_raw(BTN_raw), .UP_Max_raw(UP_Max_raw), .DN_Max_raw(DN_Max_raw),
    .Activate(Activate), .UP_Max(UP_Max), .DN_Max(DN_Max), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a debounced value flips once the last DB synchronised samples
  // all disagree with it; outputs show that value one edge later; a press pulse is
  // the cycle after the debounced button level rises (blocked by an active fault).
  bit hist [3][DB+2];  // hist[ch][k] = raw sample taken k edges ago
  bit deb  [3];
  bit lvl  [3];
  bit btn_lvl_old;
  bit act_m, fault_m, act_n, fault_n, all_diff;
  bit rawv [3];

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      deb[c] = 0;
      lvl[c] = 0;
      for (int k = 0; k < DB + 2; k++) hist[c][k] = 0;
    end
    btn_lvl_old = 0;
    act_m = 0;
    fault_m = 0;
  endtask

  always begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      model_clear();
    end else begin
      rawv[0] = BTN_raw;
      rawv[1] = UP_Max_raw;
      rawv[2] = DN_Max_raw;
`ifdef GARAGE_LIMIT_FAULT_EN
      act_n   = lvl[0] & ~btn_lvl_old & ~fault_m;
      fault_n = lvl[1] & lvl[2];
`else
      act_n   = lvl[0] & ~btn_lvl_old;
      fault_n = 0;
`endif
      btn_lvl_old = lvl[0];
      for (int c = 0; c < 3; c++) begin
        for (int k = DB + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = rawv[c];
        lvl[c] = deb[c];
        all_diff = 1;
        for (int k = 2; k <= DB + 1; k++) if (hist[c][k] == deb[c]) all_diff = 0;
        if (all_diff) deb[c] = ~deb[c];
      end
      act_m = act_n;
      fault_m = fault_n;
    end
    #1;
    check("model_activate", Activate, act_m);
    check("model_up_max", UP_Max, lvl[1]);
    check("model_dn_max", DN_Max, lvl[2]);
    check("model_fault", FAULT, fault_m);
  end

  // Drive is done on the falling edge; the next rising edge is "edge 0".
  task automatic pulse_window(input string nm, input int at, input int n);
    @(posedge CLK);
    for (int k = 1; k <= n; k++) begin
      @(posedge CLK);
      #2;
      check(nm, Activate, k == at);
    end
  endtask

  task automatic level_window(input string nm, input int ch, input int at, input int n);
    logic v;
    @(posedge CLK);
    for (int k = 1; k <= n; k++) begin
      @(posedge CLK);
      #2;
      v = (ch == 1) ? UP_Max : (ch == 2) ? DN_Max : FAULT;
      check(nm, v, k >= at);
    end
  endtask

  task automatic neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    // Asynchronous reset with all raw inputs high, before any clock edge.
    #1 RST = 1'b0;
    #1;
    check("reset_activate", Activate, 1'b0);
    check("reset_up_max", UP_Max, 1'b0);
    check("reset_dn_max", DN_Max, 1'b0);
    check("reset_fault", FAULT, 1'b0);
    #18;
    RST = 1'b1;
    BTN_raw = 0; UP_Max_raw = 0; DN_Max_raw = 0;
    neg(10);

    // Clean press held 200 ns, release, re-press.
    BTN_raw = 1;  pulse_window("press", 7, 19);
    neg(1); BTN_raw = 0; pulse_window("release", 99, 12);
    neg(1); BTN_raw = 1; pulse_window("repress", 7, 12);
    neg(1); BTN_raw = 0; neg(12);

    // Bounce into a press, then bounce during release.
    BTN_raw = 1; neg(2); BTN_raw = 0; neg(2); BTN_raw = 1; neg(2); BTN_raw = 0; neg(2);
    BTN_raw = 1; pulse_window("bounce_press", 7, 14);
    neg(1); BTN_raw = 0; neg(2); BTN_raw = 1; neg(2); BTN_raw = 0;
    pulse_window("bounce_release", 99, 14);
    neg(1); BTN_raw = 1; neg(3); BTN_raw = 0; pulse_window("glitch", 99, 12);

    // Limits: clean lower limit, short upper glitch.
    neg(1); DN_Max_raw = 1; level_window("dn_rise", 2, 6, 9);
    neg(1); UP_Max_raw = 1; neg(2); UP_Max_raw = 0; level_window("up_glitch", 1, 99, 10);

    // Both limits active, then a press.
    neg(1); UP_Max_raw = 1;
`ifdef GARAGE_LIMIT_FAULT_EN
    level_window("fault_rise", 3, 7, 10);
    neg(1); BTN_raw = 1; pulse_window("fault_press", 99, 12);
`else
    level_window("fault_off", 3, 99, 10);
    neg(1); BTN_raw = 1; pulse_window("nofault_press", 7, 12);
`endif
    neg(1); BTN_raw = 0; UP_Max_raw = 0; DN_Max_raw = 0; neg(15);

    // Reset in the middle of a held press.
    BTN_raw = 1; neg(12);
    RST = 1'b0;
    #1;
    check("midreset_activate", Activate, 1'b0);
    neg(2); RST = 1'b1; pulse_window("midreset_press", 7, 12);
    neg(1); BTN_raw = 0; neg(12);

    // Randomised phase: alternating bouncy and calm periods, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int p;
      @(negedge CLK);
      p = ((i / 200) % 2 == 0) ? 30 : 6;
      if ($urandom_range(0, 99) < p) BTN_raw = ~BTN_raw;
      if ($urandom_range(0, 99) < p) UP_Max_raw = ~UP_Max_raw;
      if ($urandom_range(0, 99) < p) DN_Max_raw = ~DN_Max_raw;
      if (!RST) RST = 1'b1;
      else if ($urandom_range(0, 999) < 2) RST = 1'b0;
    end
    @(negedge CLK); RST = 1'b1;
    neg(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
